rrf_alloc_unit: RTL
===================

# rrf_alloc_unit

Rename-register tag allocator that sits directly upstream of the rename register file in the dispatch stage. It keeps the RRF as a circular buffer and hands out up to two free tags per cycle to dispatching instructions. It drives the RRF allocate ports so the RRF clears the valid bit of each newly allocated entry. It reclaims entries in order as the commit unit retires instructions, and discards all speculative allocations on a pipeline flush.

## Interface
Parameters:
- RRF_NUM, default `RRF_NUM (64): number of RRF entries; must be a power of two.
- RRF_SEL, default `RRF_SEL (6): tag width, log2(RRF_NUM).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- req_num_i  in  2  tags requested this cycle: 0, 1 or 2. Value 3 is illegal.
- flush_i  in  1  mispredict flush; releases all uncommitted entries.
- com_num_i  in  2  entries retired this cycle: 0, 1 or 2. Value 3 is illegal.
- rrftag1_o  out  RRF_SEL  tag for the first (older) requester.
- rrftag2_o  out  RRF_SEL  tag for the second requester.
- allocate_rrf_en1_o  out  1  RRF valid-clear enable for rrftag1_o.
- allocate_rrf_en2_o  out  1  RRF valid-clear enable for rrftag2_o.
- stall_o  out  1  insufficient free entries; dispatch must hold.
- comptr_o  out  RRF_SEL  tag of the oldest uncommitted entry; the commit unit uses it as completed_dst_rrftag.
- freenum_o  out  RRF_SEL+1  number of free entries.
- error_o  out  1  sticky illegal-commit flag. Present only with the check macro; otherwise tied to 0.

## Operation
State registers:
- rrfptr (RRF_SEL bits): next tag to allocate.
- comptr (RRF_SEL bits): oldest live tag.
- freenum (RRF_SEL+1 bits): number of free entries.

Combinational outputs:
- rrftag1_o = rrfptr.
- rrftag2_o = rrfptr+1 mod RRF_NUM.
- stall_o = (freenum < req_num_i). Entries freed in the current cycle are not counted.
- accept = !stall_o && !flush_i.
- alloc_num = accept ? req_num_i : 0.
- allocate_rrf_en1_o = accept && (req_num_i >= 1).
- allocate_rrf_en2_o = accept && (req_num_i == 2).

Register updates:
- Normal cycle:
  - rrfptr += alloc_num.
  - comptr += com_num_i.
  - freenum = freenum - alloc_num + com_num_i.
- Flush cycle:
  - comptr += com_num_i.
  - rrfptr = new comptr.
  - freenum = RRF_NUM.
  - No allocation takes place.

Arithmetic and boundary rules:
- All pointer arithmetic wraps modulo RRF_NUM via natural truncation.
- freenum is never negative and never greater than RRF_NUM (given legal inputs).
- Full (freenum = 0): any request with req_num_i > 0 stalls.
- Empty (freenum = RRF_NUM): legal only when com_num_i = 0.
- req_num_i = 0 never stalls.

## Timing
- Tags, enables and stall_o are combinational from the current state and req_num_i, so there is zero-cycle latency within the dispatch cycle.
- Allocation and commit effects become visible after the next rising edge.
- A tag freed in cycle N can be allocated from cycle N+1 onward.
- Reset (asynchronous, effective immediately on assertion):
  - rrfptr = 0, comptr = 0, freenum = RRF_NUM, error_o = 0.
  - Hence stall_o = 0 when req_num_i ≤ 2.
- Reset asserted mid-operation discards all state; no partial update completes.
- Dispatch handshake: when stall_o = 1, the requester must hold req_num_i and its instructions stable until stall_o drops. No tag is consumed while stalled.

## Configuration
- RRF_ALLOC_CHECK_EN defined:
  - A commit is illegal if com_num_i > RRF_NUM - freenum, or if com_num_i = 3.
  - An illegal commit is ignored: comptr and freenum receive no commit contribution.
  - error_o sets on the next edge and stays set until reset.
  - req_num_i = 3 is treated as a stall.
- RRF_ALLOC_CHECK_EN undefined:
  - No checks are performed; error_o is constant 0.
  - Behaviour under illegal inputs is undefined.

## Test plan
- Reset, then req_num_i=2 each cycle for 32 cycles:
  - Tags 0/1, 2/3, …, 62/63 are issued, with both enables high every cycle.
  - freenum_o reaches 0; the 33rd request gives stall_o=1 with both enables at 0.
- Full buffer, req_num_i=1 and com_num_i=1 in the same cycle:
  - The request stalls that cycle.
  - Next cycle freenum_o=1, and the request gets tag 0 (wrapped).
- Start from freenum=1 with req_num_i=2: stall_o=1, and state is unchanged after the edge.
- 10 allocated, 3 committed, then flush_i=1 with com_num_i=2:
  - After the edge comptr_o=5, rrftag1_o=5, freenum_o=64.
  - A request in the flush cycle gets no enables.
- Wrap-around: allocate and commit 2 per cycle for 100 cycles.
  - Tags increase mod 64 and comptr_o trails by the in-flight count.
  - freenum_o stays constant.
- With RRF_ALLOC_CHECK_EN: from reset, com_num_i=1.
  - comptr_o stays 0 and freenum_o stays 64.
  - error_o=1 from the next cycle and remains 1 until reset_n_i is asserted low.

Source files
------------

// File: rtl/rrf_alloc_if.sv
// Dispatch/commit-side signal bundle for the rename-register tag allocator.
// master = dispatch/commit logic, slave = rrf_alloc_unit.
`ifndef RRF_SEL
`define RRF_SEL 6
`endif

interface rrf_alloc_if #(
  parameter int RRF_SEL = `RRF_SEL
);
  // Dispatch handshake: while stall_o is high the requester holds req_num_i
  // stable and no tag is consumed; a tag counts as taken only in a cycle
  // where its allocate_rrf_en*_o is high at the rising edge.
  logic [1:0]         req_num_i;
  logic               flush_i;
  logic [1:0]         com_num_i;
  logic [RRF_SEL-1:0] rrftag1_o;
  logic [RRF_SEL-1:0] rrftag2_o;
  logic               allocate_rrf_en1_o;
  logic               allocate_rrf_en2_o;
  logic               stall_o;
  logic [RRF_SEL-1:0] comptr_o;
  logic [RRF_SEL:0]   freenum_o;
  logic               error_o;

  modport master (
    output req_num_i, flush_i, com_num_i,
    input  rrftag1_o, rrftag2_o, allocate_rrf_en1_o, allocate_rrf_en2_o,
    input  stall_o, comptr_o, freenum_o, error_o
  );

  modport slave (
    input  req_num_i, flush_i, com_num_i,
    output rrftag1_o, rrftag2_o, allocate_rrf_en1_o, allocate_rrf_en2_o,
    output stall_o, comptr_o, freenum_o, error_o
  );
endinterface

// File: rtl/rrf_alloc_unit.sv
// Circular-buffer tag allocator for the rename register file: up to two tags
// per cycle, in-order reclaim on commit, full release on flush.
// Optional input checking and sticky error_o under macro RRF_ALLOC_CHECK_EN.
`ifndef RRF_NUM
`define RRF_NUM 64
`endif
`ifndef RRF_SEL
`define RRF_SEL 6
`endif

module rrf_alloc_unit #(
  parameter int RRF_NUM = `RRF_NUM,
  parameter int RRF_SEL = `RRF_SEL
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  rrf_alloc_if.slave bus
);
  localparam logic [RRF_SEL:0] FULL_CNT = (RRF_SEL+1)'(RRF_NUM);

  logic [RRF_SEL-1:0] rrfptr_q, rrfptr_d;
  logic [RRF_SEL-1:0] comptr_q, comptr_d;
  logic [RRF_SEL:0]   freenum_q, freenum_d;
  logic               stall;
  logic               accept;
  logic               com_illegal;
  logic [1:0]         alloc_num;
  logic [1:0]         com_eff;

  always_comb begin
    stall       = freenum_q < (RRF_SEL+1)'(bus.req_num_i);
    com_illegal = 1'b0;
`ifdef RRF_ALLOC_CHECK_EN
    stall       = stall || (bus.req_num_i == 2'd3);
    com_illegal = (bus.com_num_i == 2'd3) ||
                  ((RRF_SEL+1)'(bus.com_num_i) > (FULL_CNT - freenum_q));
`endif
    accept    = !stall && !bus.flush_i;
    alloc_num = accept ? bus.req_num_i : 2'd0;
    com_eff   = com_illegal ? 2'd0 : bus.com_num_i;

    comptr_d = comptr_q + RRF_SEL'(com_eff);
    // A flush drops every uncommitted tag: allocation restarts at the
    // post-commit oldest pointer and the whole buffer becomes free.
    if (bus.flush_i) begin
      rrfptr_d  = comptr_d;
      freenum_d = FULL_CNT;
    end else begin
      rrfptr_d  = rrfptr_q + RRF_SEL'(alloc_num);
      freenum_d = freenum_q - (RRF_SEL+1)'(alloc_num) + (RRF_SEL+1)'(com_eff);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rrfptr_q  <= '0;
      comptr_q  <= '0;
      freenum_q <= FULL_CNT;
    end else begin
      rrfptr_q  <= rrfptr_d;
      comptr_q  <= comptr_d;
      freenum_q <= freenum_d;
    end
  end

`ifdef RRF_ALLOC_CHECK_EN
  logic error_q, error_d;

  always_comb begin
    error_d = error_q || com_illegal;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) error_q <= 1'b0;
    else            error_q <= error_d;
  end

  assign bus.error_o = error_q;
`else
  assign bus.error_o = 1'b0;
`endif

  assign bus.rrftag1_o          = rrfptr_q;
  assign bus.rrftag2_o          = rrfptr_q + RRF_SEL'(1);
  assign bus.allocate_rrf_en1_o = accept && (bus.req_num_i != 2'd0);
  assign bus.allocate_rrf_en2_o = accept && (bus.req_num_i == 2'd2);
  assign bus.stall_o            = stall;
  assign bus.comptr_o           = comptr_q;
  assign bus.freenum_o          = freenum_q;
endmodule
